spi_cfg_arbiter: RTL
====================

Name: spi_cfg_arbiter

Overview:
- Shares one 32-bit SPI master transaction port between two requesters: the power-on auto-configuration sequencer and the IPbus-style general configuration bus.
- Serialises transactions, enforces a minimum chip-select-high gap between frames, and routes each readback word to the requester that issued it.
- Guards every transaction with a timeout so a hung SPI master cannot lock up either requester.
- Sits between the PLL/DAC config sequencers and the SimpleSPIMaster instance.

Parameters:
- CONFIG_BASE_ADDR, 32'h0020, bus address decode; a bus write is accepted when bus_addr[7:4] == CONFIG_BASE_ADDR[7:4].
- GAP_CYCLES, 20, minimum clk cycles of spi_cs high between frames (160 ns at 125 MHz).
- TIMEOUT_CYCLES, 65535, maximum clk cycles in XFER before the transaction is aborted.

Ports:
- clk  in  1  system clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- auto_req  in  1  level; the auto sequencer has a word pending on auto_data
- auto_data  in  32  frame to send for the auto sequencer
- auto_gnt  out  1  1-cycle pulse; auto_data is captured in this cycle
- auto_done  out  1  1-cycle pulse; the auto transaction has finished
- auto_rdata  out  32  readback word for the auto transaction
- bus_valid  in  1  1-cycle write strobe from the config bus
- bus_addr  in  32  bus address
- bus_data  in  32  bus frame
- bus_dout_valid  out  1  1-cycle pulse; bus readback is valid
- bus_dout_addr  out  32  address of the completed bus request
- bus_dout_data  out  32  bus readback word
- bus_busy  out  1  the bus holding register is full
- spi_wr  out  1  1-cycle start strobe to the SPI master
- spi_din  out  32  frame to the SPI master
- spi_dout_valid  in  1  SPI master completion pulse
- spi_dout  in  32  SPI master received word
- spi_cs  in  1  SPI master chip select, active low
- timeout_err  out  1  sticky flag; set on timeout
- err_clr  in  1  clears timeout_err and drop_cnt
- drop_cnt  out  8  count of dropped bus writes, saturating at 255

Behaviour:
- Reset values: all outputs 0; FSM in GAP; gap counter 0; holding register empty; last-owner = BUS, so the first tie goes to AUTO.
- Bus holding register:
  - Loaded on bus_valid when the address matches and the register is empty; stores addr and data; bus_busy=1 the following cycle.
  - bus_valid with a matching address while the register is full: the write is dropped and drop_cnt increments (saturating).
  - Non-matching addresses are ignored.
  - The register is emptied in the cycle the bus request is granted.
- FSM states IDLE, ISSUE, XFER, GAP:
  - GAP:
    - Gap counter clears while spi_cs=0 and increments while spi_cs=1.
    - Go to IDLE when counter >= GAP_CYCLES-1 and spi_cs=1.
  - IDLE:
    - Candidates are bus (holding register full) and auto (auto_req=1).
    - One candidate: grant it. Both: grant the one that is not last-owner (round robin).
    - Grant cycle: latch owner and frame; pulse auto_gnt if owner is AUTO; go to ISSUE.
  - ISSUE:
    - spi_wr=1 and spi_din=latched frame for exactly one cycle; go to XFER.
    - Grant-to-spi_wr latency is 1 cycle.
  - XFER:
    - On spi_dout_valid: route spi_dout to the owner (auto_done+auto_rdata, or bus_dout_valid+bus_dout_data+bus_dout_addr) in the following cycle; go to GAP.
    - Timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err; return 32'hDEAD_DEAD to the owner with the normal done/valid pulse; go to GAP.
- spi_din holds the last frame between transactions; spi_wr is never asserted outside ISSUE.
- Simultaneous events:
  - bus_valid in the same cycle the holding register is granted: the register counts as full and the write is dropped.
  - err_clr together with a timeout: the set wins.
- spi_dout_valid outside XFER is ignored.
- Asynchronous reset mid-transaction: everything returns to reset values. No response is issued for the in-flight request; the requester must reissue it.

Test Plan:
- Single bus write addr 0x20, data 0x0120A805 -> spi_wr exactly 3 cycles after bus_valid with spi_din=0x0120A805; after spi_dout_valid(0x000004C6), bus_dout_valid 1 cycle later with addr 0x20, data 0x000004C6.
- auto_req held and a bus write pending together, last-owner=BUS -> AUTO granted first; BUS granted in the next IDLE; spi_cs high >= 20 cycles between the two frames.
- Two bus writes 1 cycle apart -> second dropped; drop_cnt=1, bus_busy=1; err_clr -> drop_cnt=0.
- 300 matching bus writes while the SPI master is stalled -> drop_cnt saturates at 255.
- No spi_dout_valid after spi_wr -> timeout_err=1 at cycle 65535 of XFER; owner receives 0xDEADDEAD; FSM reaches IDLE after the gap.
- rst_n low during XFER -> outputs 0 immediately; after release, no stale done/valid pulse appears, and the first request sees spi_wr only after GAP_CYCLES of spi_cs high.

Source files
------------

// File: rtl/spi_cfg_arbiter_if.sv
// Request/response bundle between the two config requesters, the arbiter
// and the SPI master transaction port.
interface spi_cfg_arbiter_if;
   logic        auto_req;
   logic [31:0] auto_data;
   logic        auto_gnt;
   logic        auto_done;
   logic [31:0] auto_rdata;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_data;
   logic        bus_dout_valid;
   logic [31:0] bus_dout_addr;
   logic [31:0] bus_dout_data;
   logic        bus_busy;
   logic        spi_wr;
   logic [31:0] spi_din;
   logic        spi_dout_valid;
   logic [31:0] spi_dout;
   logic        spi_cs;
   logic        timeout_err;
   logic        err_clr;
   logic [7:0]  drop_cnt;

   modport slave (
      input  auto_req, auto_data, bus_valid, bus_addr, bus_data,
             spi_dout_valid, spi_dout, spi_cs, err_clr,
      output auto_gnt, auto_done, auto_rdata, bus_dout_valid, bus_dout_addr,
             bus_dout_data, bus_busy, spi_wr, spi_din, timeout_err, drop_cnt
   );

   modport master (
      output auto_req, auto_data, bus_valid, bus_addr, bus_data,
             spi_dout_valid, spi_dout, spi_cs, err_clr,
      input  auto_gnt, auto_done, auto_rdata, bus_dout_valid, bus_dout_addr,
             bus_dout_data, bus_busy, spi_wr, spi_din, timeout_err, drop_cnt
   );
endinterface

// File: rtl/spi_cfg_arbiter.sv
// Two-way round-robin arbiter in front of a single SPI master: serialises
// frames, enforces a CS-high gap, routes readback, and times out hung frames.
module spi_cfg_arbiter #(
   parameter logic [31:0] CONFIG_BASE_ADDR = 32'h0000_0020,
   parameter int unsigned GAP_CYCLES       = 20,
   parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
   input logic             clk,
   input logic             rst_n,
   spi_cfg_arbiter_if.slave io
);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_DEAD;

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;
   typedef enum logic {OWN_AUTO, OWN_BUS} owner_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } bus_req_t;

   state_t      state;
   owner_t      owner, last_owner;
   bus_req_t    hold;
   logic        hold_full;
   logic [31:0] frame, cur_addr;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;

   logic        addr_hit, bus_wr, drop, pick_bus, pick_auto, to_hit, resp_fire;
   logic [31:0] resp_data;

   // A real completion in the last timeout cycle wins over the abort.
   always_comb begin
      addr_hit  = io.bus_addr[7:4] == CONFIG_BASE_ADDR[7:4];
      bus_wr    = io.bus_valid && addr_hit;
      drop      = bus_wr && hold_full;
      pick_bus  = hold_full && (!io.auto_req || last_owner == OWN_AUTO);
      pick_auto = io.auto_req && !pick_bus;
      to_hit    = state == XFER && !io.spi_dout_valid && to_cnt == TW'(TIMEOUT_CYCLES - 1);
      resp_fire = state == XFER && (io.spi_dout_valid || to_hit);
      resp_data = io.spi_dout_valid ? io.spi_dout : TIMEOUT_WORD;
   end

   assign io.bus_busy = hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= GAP;
         owner             <= OWN_BUS;
         last_owner        <= OWN_BUS;
         hold              <= '0;
         hold_full         <= 1'b0;
         frame             <= '0;
         cur_addr          <= '0;
         gap_cnt           <= '0;
         to_cnt            <= '0;
         io.auto_gnt       <= 1'b0;
         io.auto_done      <= 1'b0;
         io.auto_rdata     <= '0;
         io.bus_dout_valid <= 1'b0;
         io.bus_dout_addr  <= '0;
         io.bus_dout_data  <= '0;
         io.spi_wr         <= 1'b0;
         io.spi_din        <= '0;
         io.timeout_err    <= 1'b0;
         io.drop_cnt       <= '0;
      end else begin
         io.auto_gnt       <= 1'b0;
         io.auto_done      <= 1'b0;
         io.bus_dout_valid <= 1'b0;
         io.spi_wr         <= 1'b0;

         // A write landing in the grant cycle still sees the register full.
         if (bus_wr && !hold_full) begin
            hold      <= '{addr: io.bus_addr, data: io.bus_data};
            hold_full <= 1'b1;
         end

         if (io.err_clr)
            io.drop_cnt <= '0;
         else if (drop && io.drop_cnt != 8'hFF)
            io.drop_cnt <= io.drop_cnt + 8'd1;

         if (to_hit)
            io.timeout_err <= 1'b1;
         else if (io.err_clr)
            io.timeout_err <= 1'b0;

         if (resp_fire) begin
            if (owner == OWN_AUTO) begin
               io.auto_done  <= 1'b1;
               io.auto_rdata <= resp_data;
            end else begin
               io.bus_dout_valid <= 1'b1;
               io.bus_dout_data  <= resp_data;
               io.bus_dout_addr  <= cur_addr;
            end
         end

         case (state)
            GAP: begin
               if (!io.spi_cs)
                  gap_cnt <= '0;
               else if (gap_cnt >= GW'(GAP_CYCLES - 1))
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end
            IDLE: begin
               if (pick_bus) begin
                  owner      <= OWN_BUS;
                  last_owner <= OWN_BUS;
                  frame      <= hold.data;
                  cur_addr   <= hold.addr;
                  hold_full  <= 1'b0;
                  state      <= ISSUE;
               end else if (pick_auto) begin
                  owner       <= OWN_AUTO;
                  last_owner  <= OWN_AUTO;
                  frame       <= io.auto_data;
                  io.auto_gnt <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               io.spi_wr  <= 1'b1;
               io.spi_din <= frame;
               to_cnt     <= '0;
               state      <= XFER;
            end
            XFER: begin
               if (resp_fire) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= GAP;
         endcase
      end
   end
endmodule
